// File: rtl/uart_pkg.sv
// Shared encodings, state types and small helpers for the configurable UART.
package uart_pkg;

    // Parity field encoding (2'b11 also means no parity).
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Data-bit field encoding.
    localparam logic [1:0] DB_5 = 2'd0;
    localparam logic [1:0] DB_6 = 2'd1;
    localparam logic [1:0] DB_7 = 2'd2;
    localparam logic [1:0] DB_8 = 2'd3;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP1  = 3'd4,
        TX_STOP2  = 3'd5
    } tx_state_e;

    // Number of data bits (5..8) selected by the data-bit field.
    function automatic logic [3:0] bits_from_cfg(input logic [1:0] cfg);
        return 4'd5 + {2'b00, cfg};
    endfunction

    // Mask keeping only the low nbits bits of a byte.
    function automatic logic [7:0] data_mask(input logic [3:0] nbits);
        return 8'hFF >> (4'd8 - nbits);
    endfunction

    function automatic logic parity_enabled(input logic [1:0] par);
        return (par == PAR_EVEN) || (par == PAR_ODD);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one tick every max(divisor,1) sys_clk cycles.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] reload;

    // A divisor of 0 behaves like 1 (tick every cycle).
    assign reload = (divisor == '0) ? '0 : divisor - DIV_W'(1);
    assign tick   = (cnt_q == '0);

    // Count down to zero, then reload.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
        cnt_d = cnt_q - DIV_W'(1);
        if (tick) cnt_d = reload;
    end

    // Counter register with synchronous reset to the reload value.
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!sys_rst_n) cnt_q <= reload;
        else            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_transceiver_cfg.sv
// Runtime-configurable UART (5-8 data bits, none/even/odd parity, 1/2 stop bits).
// Independent RX and TX engines share one oversample tick.
module uart_transceiver_cfg
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             uart_rx,
    output logic             uart_tx,
    input  logic [DIV_W-1:0] divisor,
    input  logic [1:0]       cfg_data_bits,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_stop2,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             rx_parity_err,
    output logic             rx_frame_err,
    output logic             rx_break,
    output logic             rx_busy,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_done,
    output logic             tx_busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] OS_MAX = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] MID_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] MID    = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] MID_P1 = CNT_W'(OVERSAMPLE / 2 + 1);

    logic tick;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .divisor   (divisor),
        .tick      (tick)
    );

    // ------------------------------------------------------------------ RX
    logic [SYNC_STAGES-1:0] rx_sync_q, rx_sync_d;
    logic                   rx_s;

    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_os_q, rx_os_d, rx_os_next;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [1:0]       rx_samp_q, rx_samp_d;
    logic             rx_par_samp_q, rx_par_samp_d;
    logic [3:0]       rx_nbits_q, rx_nbits_d;
    logic             rx_par_en_q, rx_par_en_d;
    logic             rx_par_odd_q, rx_par_odd_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_perr_q, rx_perr_d;
    logic             rx_ferr_q, rx_ferr_d;
    logic             rx_break_q, rx_break_d;
    logic             rx_busy_q, rx_busy_d;
    logic             rx_bit_val, rx_is_break;

    assign rx_sync_d = {rx_sync_q[SYNC_STAGES-2:0], uart_rx};
    assign rx_s      = rx_sync_q[SYNC_STAGES-1];

    // RX frame engine: start detect, 3-sample majority per bit, error flags.
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_os_d       = rx_os_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_samp_d     = rx_samp_q;
        rx_par_samp_d = rx_par_samp_q;
        rx_nbits_d    = rx_nbits_q;
        rx_par_en_d   = rx_par_en_q;
        rx_par_odd_d  = rx_par_odd_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_perr_d     = rx_perr_q;
        rx_ferr_d     = rx_ferr_q;
        rx_break_d    = rx_break_q;
        rx_busy_d     = rx_busy_q;
        // Counts are relative to the start-detect tick, which is count 0.
        rx_os_next    = (rx_os_q == OS_MAX) ? '0 : rx_os_q + 1'b1;
        rx_bit_val    = majority3(rx_samp_q[0], rx_samp_q[1], rx_s);
        rx_is_break   = (rx_shift_q == 8'h00) && !(rx_par_en_q && rx_par_samp_q) && !rx_bit_val;

        case (rx_state_q)
            RX_IDLE: begin
                if (tick && !rx_s) begin
                    rx_state_d   = RX_START;
                    rx_os_d      = '0;
                    rx_bit_d     = '0;
                    rx_shift_d   = '0;
                    rx_busy_d    = 1'b1;
                    rx_nbits_d   = bits_from_cfg(cfg_data_bits);
                    rx_par_en_d  = parity_enabled(cfg_parity);
                    rx_par_odd_d = (cfg_parity == PAR_ODD);
                end
            end
            RX_BREAK: begin
                if (tick && rx_s) rx_state_d = RX_IDLE;
            end
            default: begin
                if (tick) begin
                    rx_os_d = rx_os_next;
                    if (rx_os_next == MID_M1) rx_samp_d[0] = rx_s;
                    if (rx_os_next == MID)    rx_samp_d[1] = rx_s;
                    if (rx_os_next == MID_P1) begin
                        case (rx_state_q)
                            RX_START: begin
                                if (rx_bit_val) begin
                                    rx_state_d = RX_IDLE;
                                    rx_busy_d  = 1'b0;
                                end else begin
                                    rx_state_d = RX_DATA;
                                end
                            end
                            RX_DATA: begin
                                rx_shift_d[rx_bit_q] = rx_bit_val;
                                if ({1'b0, rx_bit_q} == rx_nbits_q - 4'd1)
                                    rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
                                else
                                    rx_bit_d = rx_bit_q + 3'd1;
                            end
                            RX_PARITY: begin
                                rx_par_samp_d = rx_bit_val;
                                rx_state_d    = RX_STOP;
                            end
                            RX_STOP: begin
                                rx_valid_d = 1'b1;
                                rx_busy_d  = 1'b0;
                                rx_data_d  = rx_shift_q;
                                rx_perr_d  = rx_par_en_q &&
                                             (rx_par_samp_q != ((^rx_shift_q) ^ rx_par_odd_q));
                                rx_ferr_d  = !rx_bit_val;
                                rx_break_d = rx_is_break;
                                rx_state_d = rx_is_break ? RX_BREAK : RX_IDLE;
                            end
                            default: rx_state_d = RX_IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    // RX registers; the synchroniser resets to the idle (high) line level.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rx_sync_q     <= '1;
            rx_state_q    <= RX_IDLE;
            rx_os_q       <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_samp_q     <= '0;
            rx_par_samp_q <= 1'b0;
            rx_nbits_q    <= 4'd8;
            rx_par_en_q   <= 1'b0;
            rx_par_odd_q  <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_perr_q     <= 1'b0;
            rx_ferr_q     <= 1'b0;
            rx_break_q    <= 1'b0;
            rx_busy_q     <= 1'b0;
        end else begin
            rx_sync_q     <= rx_sync_d;
            rx_state_q    <= rx_state_d;
            rx_os_q       <= rx_os_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_samp_q     <= rx_samp_d;
            rx_par_samp_q <= rx_par_samp_d;
            rx_nbits_q    <= rx_nbits_d;
            rx_par_en_q   <= rx_par_en_d;
            rx_par_odd_q  <= rx_par_odd_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_perr_q     <= rx_perr_d;
            rx_ferr_q     <= rx_ferr_d;
            rx_break_q    <= rx_break_d;
            rx_busy_q     <= rx_busy_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_break      = rx_break_q;
    assign rx_busy       = rx_busy_q;

    // ------------------------------------------------------------------ TX
    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_os_q, tx_os_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_par_bit_q, tx_par_bit_d;
    logic [3:0]       tx_nbits_q, tx_nbits_d;
    logic             tx_par_en_q, tx_par_en_d;
    logic             tx_stop2_q, tx_stop2_d;
    logic             tx_line_q, tx_line_d;
    logic             tx_busy_q, tx_busy_d;
    logic             tx_done_q, tx_done_d;
    logic [7:0]       tx_masked;

    assign tx_masked = tx_data & data_mask(bits_from_cfg(cfg_data_bits));

    // TX frame engine: each bit ends on the tick where the counter wraps.
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_os_d      = tx_os_q;
        tx_bit_d     = tx_bit_q;
        tx_shift_d   = tx_shift_q;
        tx_par_bit_d = tx_par_bit_q;
        tx_nbits_d   = tx_nbits_q;
        tx_par_en_d  = tx_par_en_q;
        tx_stop2_d   = tx_stop2_q;
        tx_line_d    = tx_line_q;
        tx_busy_d    = tx_busy_q;
        tx_done_d    = 1'b0;

        if (tx_state_q == TX_IDLE) begin
            if (tx_valid) begin
                tx_state_d   = TX_START;
                tx_os_d      = '0;
                tx_bit_d     = '0;
                tx_shift_d   = tx_masked;
                tx_par_bit_d = (^tx_masked) ^ (cfg_parity == PAR_ODD);
                tx_nbits_d   = bits_from_cfg(cfg_data_bits);
                tx_par_en_d  = parity_enabled(cfg_parity);
                tx_stop2_d   = cfg_stop2;
                tx_line_d    = 1'b0;
                tx_busy_d    = 1'b1;
            end
        end else if (tick) begin
            tx_os_d = (tx_os_q == OS_MAX) ? '0 : tx_os_q + 1'b1;
            if (tx_os_q == OS_MAX) begin
                case (tx_state_q)
                    TX_START: begin
                        tx_state_d = TX_DATA;
                        tx_line_d  = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                    end
                    TX_DATA: begin
                        if ({1'b0, tx_bit_q} == tx_nbits_q - 4'd1) begin
                            tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP1;
                            tx_line_d  = tx_par_en_q ? tx_par_bit_q : 1'b1;
                        end else begin
                            tx_bit_d   = tx_bit_q + 3'd1;
                            tx_line_d  = tx_shift_q[0];
                            tx_shift_d = tx_shift_q >> 1;
                        end
                    end
                    TX_PARITY: begin
                        tx_state_d = TX_STOP1;
                        tx_line_d  = 1'b1;
                    end
                    TX_STOP1: begin
                        tx_line_d = 1'b1;
                        if (tx_stop2_q) begin
                            tx_state_d = TX_STOP2;
                        end else begin
                            tx_state_d = TX_IDLE;
                            tx_busy_d  = 1'b0;
                            tx_done_d  = 1'b1;
                        end
                    end
                    default: begin
                        tx_state_d = TX_IDLE;
                        tx_line_d  = 1'b1;
                        tx_busy_d  = 1'b0;
                        tx_done_d  = 1'b1;
                    end
                endcase
            end
        end
    end

    // TX registers; the line idles high.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            tx_state_q   <= TX_IDLE;
            tx_os_q      <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            tx_par_bit_q <= 1'b0;
            tx_nbits_q   <= 4'd8;
            tx_par_en_q  <= 1'b0;
            tx_stop2_q   <= 1'b0;
            tx_line_q    <= 1'b1;
            tx_busy_q    <= 1'b0;
            tx_done_q    <= 1'b0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_os_q      <= tx_os_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            tx_par_bit_q <= tx_par_bit_d;
            tx_nbits_q   <= tx_nbits_d;
            tx_par_en_q  <= tx_par_en_d;
            tx_stop2_q   <= tx_stop2_d;
            tx_line_q    <= tx_line_d;
            tx_busy_q    <= tx_busy_d;
            tx_done_q    <= tx_done_d;
        end
    end

    assign uart_tx  = tx_line_q;
    assign tx_ready = (tx_state_q == TX_IDLE);
    assign tx_done  = tx_done_q;
    assign tx_busy  = tx_busy_q;

endmodule

// File: tb/tb_uart_transceiver_cfg.sv
// Directed bench for uart_transceiver_cfg: OVERSAMPLE=16, divisor=4 (64 cycles per bit).
module tb_uart_transceiver_cfg;

    localparam int BIT = 64;
    localparam int CAP = 1000;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        uart_rx, uart_tx;
    logic [15:0] divisor = 16'd4;
    logic [1:0]  cfg_data_bits = 2'd3;
    logic [1:0]  cfg_parity = 2'b00;
    logic        cfg_stop2 = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_busy;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready, tx_done, tx_busy;

    logic rx_drv = 1'b1;
    logic loopback = 1'b0;

    assign uart_rx = loopback ? uart_tx : rx_drv;

    uart_transceiver_cfg #(.OVERSAMPLE(16), .DIV_W(16), .SYNC_STAGES(2)) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .uart_rx       (uart_rx),
        .uart_tx       (uart_tx),
        .divisor       (divisor),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_break      (rx_break),
        .rx_busy       (rx_busy),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_done       (tx_done),
        .tx_busy       (tx_busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor state collected once per cycle.
    int         rxv_cnt;
    int         done_cnt;
    bit         busy_seen;
    logic [7:0] rx_last;
    logic       pe_last, fe_last, brk_last;

    logic wave  [CAP];
    logic dwave [CAP];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge.
    task automatic step();
        @(posedge sys_clk);
        #1;
        if (rx_valid) begin
            rxv_cnt++;
            rx_last  = rx_data;
            pe_last  = rx_parity_err;
            fe_last  = rx_frame_err;
            brk_last = rx_break;
        end
        if (rx_busy) busy_seen = 1'b1;
        if (tx_done) done_cnt++;
    endtask

    task automatic clear_mon();
        rxv_cnt   = 0;
        done_cnt  = 0;
        busy_seen = 1'b0;
        rx_last   = 8'hxx;
        pe_last   = 1'bx;
        fe_last   = 1'bx;
        brk_last  = 1'bx;
    endtask

    function automatic logic wv(input int i);
        if (i < 0 || i >= CAP) return 1'bx;
        return wave[i];
    endfunction

    function automatic logic dv(input int i);
        if (i < 0 || i >= CAP) return 1'bx;
        return dwave[i];
    endfunction

    // Send one frame, capture the line, and check timing, bit values, tx_done and
    // (when looped back) the received word. Data bit 0 must be 1 so the start
    // bit length can be measured from the line.
    task automatic run_tx(input string tag, input logic [7:0] d, input int nb,
                          input logic [1:0] par, input logic st2, input bit hold);
        logic exp_bits [12];
        int   len, l0, last, mism, dcount;
        logic p;
        logic [7:0] dm;

        clear_mon();
        cfg_data_bits = 2'(nb - 5);
        cfg_parity    = par;
        cfg_stop2     = st2;
        tx_data       = d;
        check({tag, "_ready"}, 32'(tx_ready), 32'd1);
        tx_valid = 1'b1;
        step();
        if (!hold) tx_valid = 1'b0;
        check({tag, "_busy"}, 32'(tx_busy), 32'd1);

        for (int c = 0; c < CAP; c++) begin
            wave[c]  = uart_tx;
            dwave[c] = tx_done;
            // Scramble the configuration mid-frame; the frame must not change.
            if (c == 20) begin
                cfg_data_bits = ~cfg_data_bits;
                cfg_parity    = (par == 2'b01 || par == 2'b10) ? 2'b00 : 2'b01;
                cfg_stop2     = ~st2;
            end
            step();
        end

        // Expected frame after the start bit.
        len = 0;
        dm  = 8'h00;
        p   = 1'b0;
        for (int i = 0; i < nb; i++) begin
            exp_bits[len] = d[i];
            len++;
            dm[i] = d[i];
            p     = p ^ d[i];
        end
        if (par == 2'b01 || par == 2'b10) begin
            exp_bits[len] = (par == 2'b10) ? ~p : p;
            len++;
        end
        exp_bits[len] = 1'b1;
        len++;
        if (st2) begin
            exp_bits[len] = 1'b1;
            len++;
        end

        check({tag, "_start_lvl"}, 32'(wv(0)), 32'd0);
        l0 = -1;
        for (int c = 0; c < CAP; c++) if (l0 < 0 && wave[c] === 1'b1) l0 = c;
        check({tag, "_start_len"}, 32'(l0 >= 15 * 4 && l0 <= BIT), 32'd1);
        if (l0 < 0) l0 = BIT;

        for (int b = 0; b < len; b++) begin
            mism = 0;
            for (int j = 0; j < BIT; j++) if (wv(l0 + b * BIT + j) !== exp_bits[b]) mism++;
            check($sformatf("%s_bit%0d_bad_cycles", tag, b), 32'(mism), 32'd0);
        end

        last   = l0 + len * BIT;
        dcount = 0;
        for (int c = 0; c < CAP; c++) if (dwave[c] === 1'b1) dcount++;
        check({tag, "_done_at_end"}, 32'(dv(last)), 32'd1);
        check({tag, "_done_count"}, 32'(dcount), 32'd1);
        if (hold) begin
            check({tag, "_idle_at_done"}, 32'(wv(last)), 32'd1);
            check({tag, "_b2b_start"}, 32'(wv(last + 1)), 32'd0);
        end

        if (loopback) begin
            check({tag, "_rx_count"}, 32'(rxv_cnt), 32'd1);
            check({tag, "_rx_data"}, 32'(rx_last), 32'(dm));
            check({tag, "_rx_perr"}, 32'(pe_last), 32'd0);
            check({tag, "_rx_ferr"}, 32'(fe_last), 32'd0);
            check({tag, "_rx_brk"}, 32'(brk_last), 32'd0);
        end

        tx_valid = 1'b0;
        for (int i = 0; i < 3000 && tx_busy; i++) step();
        check({tag, "_tx_drained"}, 32'(tx_busy), 32'd0);
    endtask

    // Drive a start bit followed by len bits (LSB first) on the RX line, then idle.
    task automatic drive_rx(input logic [11:0] bits, input int len);
        rx_drv = 1'b0;
        repeat (BIT) step();
        for (int b = 0; b < len; b++) begin
            rx_drv = bits[b];
            repeat (BIT) step();
        end
        rx_drv = 1'b1;
        repeat (BIT) step();
    endtask

    initial begin
        clear_mon();

        // Reset state.
        repeat (4) step();
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_flags", 32'({rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_busy}), 32'd0);
        sys_rst_n = 1'b1;
        repeat (5) step();

        // 8N1 0xA5 looped back.
        loopback = 1'b1;
        run_tx("8n1_a5", 8'hA5, 8, 2'b00, 1'b0, 1'b0);

        // 7E1 0x35 looped back: parity bit 0 on the line.
        run_tx("7e1_35", 8'h35, 7, 2'b01, 1'b0, 1'b0);

        // Same 7E1 frame driven externally with the parity bit flipped to 1.
        loopback      = 1'b0;
        cfg_data_bits = 2'd2;
        cfg_parity    = 2'b01;
        clear_mon();
        drive_rx({3'b000, 1'b1, 1'b1, 7'h35}, 9);
        check("7e1_bad_count", 32'(rxv_cnt), 32'd1);
        check("7e1_bad_data", 32'(rx_last), 32'h35);
        check("7e1_bad_perr", 32'(pe_last), 32'd1);
        check("7e1_bad_ferr", 32'(fe_last), 32'd0);

        // 5O2 0x1F with tx_valid held: back-to-back start after tx_done.
        loopback = 1'b1;
        run_tx("5o2_1f", 8'h1F, 5, 2'b10, 1'b1, 1'b1);

        // Short low glitch on RX: busy pulses, nothing reported.
        loopback      = 1'b0;
        cfg_data_bits = 2'd3;
        cfg_parity    = 2'b00;
        cfg_stop2     = 1'b0;
        repeat (BIT) step();
        clear_mon();
        rx_drv = 1'b0;
        repeat (20) step();
        rx_drv = 1'b1;
        repeat (100) step();
        check("glitch_busy_seen", 32'(busy_seen), 32'd1);
        check("glitch_no_valid", 32'(rxv_cnt), 32'd0);
        check("glitch_idle", 32'(rx_busy), 32'd0);
        clear_mon();
        drive_rx({3'b000, 1'b1, 8'h3C}, 9);
        check("after_glitch_count", 32'(rxv_cnt), 32'd1);
        check("after_glitch_data", 32'(rx_last), 32'h3C);
        check("after_glitch_flags", 32'({pe_last, fe_last, brk_last}), 32'd0);

        // Line held low for 15 bit times: one break report only.
        clear_mon();
        rx_drv = 1'b0;
        repeat (15 * BIT) step();
        check("break_count", 32'(rxv_cnt), 32'd1);
        check("break_data", 32'(rx_last), 32'h00);
        check("break_ferr", 32'(fe_last), 32'd1);
        check("break_flag", 32'(brk_last), 32'd1);
        check("break_perr", 32'(pe_last), 32'd0);
        check("break_not_busy", 32'(rx_busy), 32'd0);
        rx_drv = 1'b1;
        repeat (BIT) step();
        clear_mon();
        drive_rx({3'b000, 1'b1, 8'h5A}, 9);
        check("after_break_count", 32'(rxv_cnt), 32'd1);
        check("after_break_data", 32'(rx_last), 32'h5A);
        check("after_break_flags", 32'({pe_last, fe_last, brk_last}), 32'd0);

        // Reset during TX data bit 3 aborts the frame.
        cfg_data_bits = 2'd3;
        cfg_parity    = 2'b00;
        tx_data       = 8'hA5;
        tx_valid      = 1'b1;
        step();
        tx_valid = 1'b0;
        clear_mon();
        repeat (288) step();
        check("mid_bit3_line", 32'(uart_tx), 32'd0);
        check("mid_bit3_busy", 32'(tx_busy), 32'd1);
        sys_rst_n = 1'b0;
        step();
        sys_rst_n = 1'b1;
        check("abort_uart_tx", 32'(uart_tx), 32'd1);
        check("abort_tx_busy", 32'(tx_busy), 32'd0);
        check("abort_tx_ready", 32'(tx_ready), 32'd1);
        repeat (800) step();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_line_idle", 32'(uart_tx), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_transceiver_cfg.md
Name: uart_transceiver_cfg

Overview:
Parametrised successor to the fixed 8N1 UART transceiver for SoC serial peripherals (console, debug link).
- Runtime-configurable frame format: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits.
- Parametrised oversampling and divisor width; majority-of-3 RX sampling.
- Parity, framing and break error reporting.
- TX uses a valid/ready handshake.
- Sits between the bus-side UART register block and the pads.

Parameters:
- OVERSAMPLE, 16: ticks per bit; even, >= 4.
- DIV_W, 16: width of the divisor input.
- SYNC_STAGES, 2: uart_rx synchroniser depth; >= 2.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  synchronous active-low reset.
- uart_rx  in  1  serial input, asynchronous.
- uart_tx  out  1  serial output, idle high.
- divisor  in  DIV_W  sys_clk cycles per tick; 0 is treated as 1.
- cfg_data_bits  in  2  data bits: 0=5, 1=6, 2=7, 3=8.
- cfg_parity  in  2  parity: 00 none, 01 even, 10 odd, 11 none.
- cfg_stop2  in  1  1 = two TX stop bits.
- rx_data  out  8  received word, LSB-aligned, upper bits zero.
- rx_valid  out  1  one-cycle pulse per completed frame.
- rx_parity_err  out  1  valid with rx_valid.
- rx_frame_err  out  1  valid with rx_valid.
- rx_break  out  1  valid with rx_valid.
- rx_busy  out  1  RX frame in progress.
- tx_data  in  8  word to send; bits above the data width are ignored.
- tx_valid  in  1  TX request.
- tx_ready  out  1  TX able to accept.
- tx_done  out  1  one-cycle pulse at the end of the last stop bit.
- tx_busy  out  1  TX frame in progress.

Behaviour:
- Reset values (sys_rst_n low at an edge):
  - uart_tx=1, tx_ready=1.
  - rx_data=0; all pulses, flags and busy outputs 0.
  - Tick counter loads max(divisor,1)-1.
  - Both FSMs go idle.
- Reset applied mid-frame aborts that frame with no tx_done and no rx_valid.
- Tick generator:
  - tick=1 when the counter is 0, then reload max(divisor,1)-1; otherwise decrement.
  - Shared by RX and TX.
- Configuration capture: cfg_* is latched at frame start (TX accept / RX start detect). Mid-frame changes do not affect that frame.
- RX FSM: RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK.
  - RX_IDLE: on a tick with synced rx=0, clear the oversample counter to 0, set rx_busy=1, go to RX_START.
  - Sampling: each bit uses the majority of synced rx at oversample counts MID-1, MID, MID+1 (MID=OVERSAMPLE/2). The bit is decided at MID+1. Bit periods are OVERSAMPLE ticks, measured from start detect.
  - RX_START: majority 1 → back to RX_IDLE (glitch), no rx_valid. Majority 0 → RX_DATA.
  - RX_DATA: shifts bits LSB-first, then goes to RX_PARITY if parity is enabled, else RX_STOP.
  - RX_PARITY: rx_parity_err = received parity bit differs from expected (even: XOR of data; odd: inverted XOR).
  - RX_STOP: samples the first stop bit only, regardless of cfg_stop2. One cycle after the decision: rx_valid=1, rx_data updated, flags updated, rx_busy=0.
  - rx_frame_err = stop sample was 0.
  - rx_break = data all 0 AND parity sample 0 (if enabled) AND stop sample 0.
  - After a break, go to RX_BREAK. Stay there until a tick sees synced rx=1, then RX_IDLE. No further frames are reported while the line stays low.
  - Non-break frames return directly to RX_IDLE; flags hold until the next rx_valid.
- TX FSM: TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2.
  - tx_ready = (state==TX_IDLE).
  - Accept on tx_valid && tx_ready: latch data and cfg, clear the oversample counter. Next cycle uart_tx=0 and tx_busy=1.
  - Each bit ends on the tick where the counter wraps from OVERSAMPLE-1.
  - The start bit lasts between (OVERSAMPLE-1)·div and OVERSAMPLE·div cycles; every later bit lasts exactly OVERSAMPLE·div cycles.
  - Bit order: data LSB-first, then optional parity, then 1 or 2 stop bits (high).
  - At the end of the last stop bit: tx_done=1, tx_busy=0, state TX_IDLE. tx_ready is high in that same cycle, so back-to-back accepts add no idle gap.
  - tx_valid while busy is ignored and not queued.
- RX and TX are fully independent: they may run simultaneously, including loopback.

Decomposition:
- Package uart_pkg holds:
  - parity encoding constants (PAR_NONE, PAR_EVEN, PAR_ODD);
  - data-bit encoding and the function bits_from_cfg();
  - RX and TX state enums.
- One sub-module, uart_baud_gen: divisor → tick generator, parametrised by DIV_W.

Test Plan:
Common setup: OVERSAMPLE=16, divisor=4, so one bit = 64 cycles.
- 8N1, send 0xA5 with uart_tx looped to uart_rx:
  - uart_tx bits 0,1,0,1,0,0,1,0,1,1, each 64 cycles;
  - one tx_done;
  - rx_valid with rx_data=0xA5 and all error flags 0.
- 7E1, send 0x35: parity bit 0 on the line, rx_data=0x35, rx_parity_err=0. Same frame driven externally with the parity bit flipped → rx_parity_err=1, rx_data=0x35.
- 5O2, send 0x1F: data 1,1,1,1,1, parity 0, then stop high for 128 cycles before tx_done. tx_valid held high → next start bit begins the cycle after tx_done.
- uart_rx low for 20 cycles, then high: rx_busy pulses, no rx_valid; RX is idle and a following 8N1 0x3C is received correctly.
- uart_rx held low for 15 bit times:
  - exactly one rx_valid with rx_data=0x00, rx_frame_err=1, rx_break=1;
  - next frame is received only after the line returns high.
- sys_rst_n low for one cycle during TX data bit 3: next cycle uart_tx=1, tx_busy=0, tx_ready=1; tx_done never pulses.
